spi_slave_fd: RTL and testbench
===============================

Name: spi_slave_fd

Overview:
Parametrised full-duplex SPI slave and the successor to the 8-bit receive-only slave. It supports configurable frame width, all four CPOL/CPHA modes and MSB- or LSB-first bit order. It transmits on MISO from a one-entry holding register and receives back-to-back frames without CS toggling. It sits between an off-chip SPI master and an on-chip register or stream consumer, all in the clk domain.

Parameters:
N, 8, frame width in bits (>=2)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth for SCK/MOSI/CS (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active low
SCK  in  1  SPI clock, asynchronous to clk
CS  in  1  chip select, active low, asynchronous
MOSI  in  1  master-out data
MISO  out  1  slave-out data
miso_oe  out  1  MISO output enable, high while synced CS is low
tx_data  in  N  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
rx_data  out  N  last complete received word
rx_valid  out  1  one-cycle pulse: rx_data updated
frame_err  out  1  one-cycle pulse: CS rose mid-frame
underrun  out  1  one-cycle pulse: frame started with empty holding register
busy  out  1  high in LOAD/XFER

Behaviour:
- Reset values: MISO 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, frame_err 0, underrun 0, busy 0, state IDLE.
- Reset is asynchronous and active-low. Asserting it mid-frame aborts immediately with no pulses. The holding register is emptied.
- Synchronisers: SYNC_STAGES flops each. CS resets to 1; SCK resets to CPOL; MOSI resets to 0.
- Edges are detected on the last two synchronised SCK samples. The sample edge is rising when CPOL==CPHA, else falling. The shift edge is the opposite edge.
- Timing requirement: SCK high and low times each >= SYNC_STAGES+2 clk cycles.
- Holding register: accepts tx_data when tx_valid && tx_ready. tx_ready drops the next cycle and rises again when the word moves into the tx shift register.
- States: IDLE, LOAD, XFER, DONE.
- IDLE -> LOAD on synced CS low.
- LOAD (1 cycle): the tx shift register is loaded from the holding register. If the holding register is empty, all-zeros are loaded and underrun pulses. bit_cnt (width $clog2(N)) is set to N-1. MISO is driven with the first bit. LOAD -> XFER.
- XFER, sample edge: the MOSI bit is shifted into rx_shift (MSB- or LSB-first per MSB_FIRST). If bit_cnt==0, go to DONE; else decrement bit_cnt.
- XFER, shift edge: MISO advances to the next bit. Exception: with CPHA=1, the first shift edge presents bit 0 of the frame and does not advance.
- DONE (1 cycle): rx_data is loaded with the completed word and rx_valid pulses.
  - CS still low: go to LOAD (back-to-back frame). The first sample edge of the next frame must not occur within 1 clk.
  - CS high: go to IDLE.
- CS rising in LOAD or XFER: frame_err pulses, the partial word is discarded, rx_data is unchanged, no rx_valid, go to IDLE. A CS rise on the same cycle as the final sample edge counts as complete: rx_valid pulses, no frame_err.
- A tx_valid handshake during XFER fills the holding register for the next frame.
- Arithmetic: bit_cnt wraps only via reload. No overflow is reachable.

Decomposition:
- Shared package spi_pkg: state_t enum (IDLE/LOAD/XFER/DONE) and a function sample_on_rising(CPOL,CPHA). The SPI mode localparams also live in spi_pkg.
- Sub-module spi_sync: parametrised depth and reset value, instantiated once each for SCK, MOSI and CS.

Test Plan:
- Mode 0, N=8, MSB-first: preload tx 0x3C, master sends 0xA5 -> rx_data=0xA5 with one rx_valid pulse; master receives 0x3C; tx_ready low->high at LOAD.
- Mode 3, then mode 1: same bytes -> identical results; MISO bit 7 is stable before the first sample edge in both modes.
- Back-to-back: CS held low for frames 0x11 then 0x22, with tx 0xAA refilled during frame 1 and 0xBB after -> two rx_valid pulses with 0x11/0x22; master receives 0xAA/0xBB; no frame_err.
- Abort: CS rises after 5 bits of 0xFF -> frame_err pulse, rx_data keeps its previous value 0xA5, no rx_valid, state IDLE.
- Underrun and LSB-first: N=16, MSB_FIRST=0, no tx_valid, master sends 0x1234 -> underrun pulse, MISO all zeros, rx_data=0x1234.
- Reset mid-frame: assert reset after 3 bits -> all outputs at reset values next cycle; the following full frame 0x5A is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, SPI mode constants and edge-selection helper
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER,
    DONE
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Modes 0 and 3 capture MOSI on the rising SCK edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rising(input logic cpol, input logic cpha);
    logic rise;
    case ({cpol, cpha})
      SPI_MODE0, SPI_MODE3: rise = 1'b1;
      SPI_MODE1, SPI_MODE2: rise = 1'b0;
      default:              rise = 1'b0;
    endcase
    return rise;
  endfunction

endpackage

// File: rtl/spi_slave_fd_if.sv
// rtl/spi_slave_fd_if.sv - SPI pins and tx/rx word handshakes of the full-duplex slave
interface spi_slave_fd_if #(
  parameter int N = 8
);
  logic         SCK;
  logic         CS;
  logic         MOSI;
  logic         MISO;
  logic         miso_oe;
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         underrun;
  logic         busy;

  modport slave (
    input  SCK, CS, MOSI, tx_data, tx_valid,
    output MISO, miso_oe, tx_ready, rx_data, rx_valid, frame_err, underrun, busy
  );

  modport master (
    output SCK, CS, MOSI, tx_data, tx_valid,
    input  MISO, miso_oe, tx_ready, rx_data, rx_valid, frame_err, underrun, busy
  );
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchroniser with configurable depth and reset value
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through STAGES flops into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {STAGES{RST_VAL}};
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/spi_slave_fd.sv
// rtl/spi_slave_fd.sv - parametrised full-duplex SPI slave with one-entry tx holding register
module spi_slave_fd
  import spi_pkg::*;
#(
  parameter int N           = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  spi_slave_fd_if.slave bus
);
  localparam int            CW          = $clog2(N);
  localparam logic [CW-1:0] LAST        = CW'(N - 1);
  localparam logic          SAMPLE_RISE = sample_on_rising(1'(CPOL), 1'(CPHA));

  logic         w_sck, w_cs, w_mosi;
  logic         r_sck_d;
  logic         w_sample_edge, w_shift_edge;
  state_t       r_state, w_state_next;
  logic         w_frame_err;
  logic [N-1:0] r_tx_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic         r_tx_full, r_miso, r_rx_valid, r_frame_err, r_underrun;
  logic [CW-1:0] r_bit_cnt;
  logic         w_tx_accept, w_advance;
  logic [N-1:0] w_load_word, w_tx_next;
  logic         w_load_first, w_next_first;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sck (
    .clk(clk), .rst_n(reset), .i_d(bus.SCK), .o_q(w_sck)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(reset), .i_d(bus.CS), .o_q(w_cs)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .i_d(bus.MOSI), .o_q(w_mosi)
  );

  // Previous synchronised SCK sample, paired with the current one for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sck_d <= 1'(CPOL);
    else        r_sck_d <= w_sck;
  end

  assign w_sample_edge = SAMPLE_RISE ? (w_sck && !r_sck_d) : (!w_sck && r_sck_d);
  assign w_shift_edge  = SAMPLE_RISE ? (!w_sck && r_sck_d) : (w_sck && !r_sck_d);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state; a CS rise only flags an error once part of a word has been captured,
  // so the speculative LOAD/XFER that follows every completed frame ends quietly.
  always_comb begin
    w_state_next = r_state;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE: if (!w_cs) w_state_next = LOAD;
      LOAD: w_state_next = w_cs ? IDLE : XFER;
      XFER: begin
        if (w_sample_edge && (r_bit_cnt == '0)) begin
          w_state_next = DONE;
        end else if (w_cs) begin
          w_state_next = IDLE;
          w_frame_err  = (r_bit_cnt != LAST) || w_sample_edge;
        end
      end
      DONE:    w_state_next = w_cs ? IDLE : LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tx_accept  = bus.tx_valid && !r_tx_full;
  assign w_load_word  = r_tx_full ? r_tx_hold : '0;
  assign w_tx_next    = (MSB_FIRST != 0) ? {r_tx_shift[N-2:0], 1'b0} : {1'b0, r_tx_shift[N-1:1]};
  assign w_load_first = (MSB_FIRST != 0) ? w_load_word[N-1] : w_load_word[0];
  assign w_next_first = (MSB_FIRST != 0) ? w_tx_next[N-1] : w_tx_next[0];
  // Shift edges before the first sample of a frame never advance MISO: with CPHA=1 that
  // edge presents bit 0, with CPHA=0 it is the tail of the previous back-to-back frame.
  assign w_advance    = (r_state == XFER) && w_shift_edge && (r_bit_cnt != LAST);

  // Holding register: filled by the tx handshake, emptied when LOAD takes the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_hold <= '0;
      r_tx_full <= 1'b0;
    end else begin
      if (w_tx_accept) begin
        r_tx_hold <= bus.tx_data;
        r_tx_full <= 1'b1;
      end
      if ((r_state == LOAD) && r_tx_full) r_tx_full <= 1'b0;
    end
  end

  // Transmit shift register and MISO bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else if (r_state == LOAD) begin
      r_tx_shift <= w_load_word;
      r_miso     <= w_load_first;
    end else if (w_advance) begin
      r_tx_shift <= w_tx_next;
      r_miso     <= w_next_first;
    end
  end

  // Bit counter and receive shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
    end else if (r_state == LOAD) begin
      r_bit_cnt <= LAST;
    end else if ((r_state == XFER) && w_sample_edge) begin
      r_rx_shift <= (MSB_FIRST != 0) ? {r_rx_shift[N-2:0], w_mosi} : {w_mosi, r_rx_shift[N-1:1]};
      if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - CW'(1);
    end
  end

  // Received word and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid  <= (r_state == DONE);
      r_frame_err <= w_frame_err;
      r_underrun  <= (r_state == LOAD) && !r_tx_full;
      if (r_state == DONE) r_rx_data <= r_rx_shift;
    end
  end

  assign bus.MISO      = r_miso;
  assign bus.miso_oe   = !w_cs;
  assign bus.tx_ready  = !r_tx_full;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.underrun  = r_underrun;
  assign bus.busy      = (r_state == LOAD) || (r_state == XFER);
endmodule

// File: tb/tb_spi_slave_fd.sv
// tb/tb_spi_slave_fd.sv - self-checking bench for spi_slave_fd across modes, widths and bit orders
module tb_spi_slave_fd;
  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_sck = 1'b0, m_cs = 1'b1, m_mosi = 1'b0, m_txv = 1'b0;
  logic [15:0] m_txd = '0;
  int          sel = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  spi_slave_fd_if #(.N(8))  if0 ();
  spi_slave_fd_if #(.N(8))  if3 ();
  spi_slave_fd_if #(.N(8))  if1 ();
  spi_slave_fd_if #(.N(16)) if16 ();

  assign if0.SCK      = (sel == 0) ? m_sck : 1'b0;
  assign if0.CS       = (sel == 0) ? m_cs : 1'b1;
  assign if0.MOSI     = m_mosi;
  assign if0.tx_data  = m_txd[7:0];
  assign if0.tx_valid = (sel == 0) && m_txv;
  assign if3.SCK      = (sel == 1) ? m_sck : 1'b1;
  assign if3.CS       = (sel == 1) ? m_cs : 1'b1;
  assign if3.MOSI     = m_mosi;
  assign if3.tx_data  = m_txd[7:0];
  assign if3.tx_valid = (sel == 1) && m_txv;
  assign if1.SCK      = (sel == 2) ? m_sck : 1'b0;
  assign if1.CS       = (sel == 2) ? m_cs : 1'b1;
  assign if1.MOSI     = m_mosi;
  assign if1.tx_data  = m_txd[7:0];
  assign if1.tx_valid = (sel == 2) && m_txv;
  assign if16.SCK      = (sel == 3) ? m_sck : 1'b0;
  assign if16.CS       = (sel == 3) ? m_cs : 1'b1;
  assign if16.MOSI     = m_mosi;
  assign if16.tx_data  = m_txd;
  assign if16.tx_valid = (sel == 3) && m_txv;

  spi_slave_fd #(.N(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  spi_slave_fd #(.N(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));
  spi_slave_fd #(.N(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  spi_slave_fd #(.N(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .bus(if16));

  logic w_miso;
  always_comb begin
    case (sel)
      0:       w_miso = if0.MISO;
      1:       w_miso = if3.MISO;
      2:       w_miso = if1.MISO;
      default: w_miso = if16.MISO;
    endcase
  end

  // Pulse counters; und_snap holds the underrun count seen when a frame's rx_valid fires.
  int rxv_cnt[4], ferr_cnt[4], und_cnt[4], und_snap[4];
  logic [3:0] w_rxv, w_ferr, w_und;
  assign w_rxv  = {if16.rx_valid, if1.rx_valid, if3.rx_valid, if0.rx_valid};
  assign w_ferr = {if16.frame_err, if1.frame_err, if3.frame_err, if0.frame_err};
  assign w_und  = {if16.underrun, if1.underrun, if3.underrun, if0.underrun};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_rxv[k]) begin
        rxv_cnt[k]  <= rxv_cnt[k] + 1;
        und_snap[k] <= und_cnt[k];
      end
      if (w_ferr[k]) ferr_cnt[k] <= ferr_cnt[k] + 1;
      if (w_und[k])  und_cnt[k]  <= und_cnt[k] + 1;
    end
  end

  function automatic logic [15:0] rx_of(input int k);
    case (k)
      0:       return {8'h00, if0.rx_data};
      1:       return {8'h00, if3.rx_data};
      2:       return {8'h00, if1.rx_data};
      default: return if16.rx_data;
    endcase
  endfunction

  function automatic logic ready_of(input int k);
    case (k)
      0:       return if0.tx_ready;
      1:       return if3.tx_ready;
      2:       return if1.tx_ready;
      default: return if16.tx_ready;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    m_txd = w;
    m_txv = 1'b1;
    @(negedge clk);
    m_txv = 1'b0;
  endtask

  task automatic select(input int k, input logic idle);
    m_sck = idle;
    sel   = k;
    wait_clk(2);
  endtask

  // SPI master: clocks nbits of mo and gathers MISO, placing each bit by frame position.
  task automatic frame(input int cpol, input int cpha, input int n, input bit msbf,
                       input logic [15:0] mo, input int nbits, input bit end_cs,
                       input bit refill, input logic [15:0] rw,
                       output logic [15:0] mi, output logic first);
    int pos;
    mi    = '0;
    m_sck = 1'(cpol);
    m_cs  = 1'b0;
    if (cpha == 0) m_mosi = mo[msbf ? n - 1 : 0];
    wait_clk(HALF);
    first = w_miso;
    for (int i = 0; i < nbits; i++) begin
      pos = msbf ? n - 1 - i : i;
      if (cpha != 0) m_mosi = mo[pos];
      m_sck = ~1'(cpol);
      if (cpha == 0) mi[pos] = w_miso;
      wait_clk(HALF);
      m_sck = 1'(cpol);
      if (cpha != 0) mi[pos] = w_miso;
      else if (i + 1 < n) m_mosi = mo[msbf ? n - 2 - i : i + 1];
      if (refill && i == 3) begin
        push(rw);
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
    end
    if (end_cs) begin
      m_cs = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},      32'(if0.MISO), 0);
    check({tag, "_miso_oe"},   32'(if0.miso_oe), 0);
    check({tag, "_tx_ready"},  32'(if0.tx_ready), 1);
    check({tag, "_rx_data"},   32'(if0.rx_data), 0);
    check({tag, "_rx_valid"},  32'(if0.rx_valid), 0);
    check({tag, "_frame_err"}, 32'(if0.frame_err), 0);
    check({tag, "_underrun"},  32'(if0.underrun), 0);
    check({tag, "_busy"},      32'(if0.busy), 0);
  endtask

  initial begin
    logic [15:0] mi, mi2, w, e;
    logic        fb;
    int          b_rxv, b_ferr, b_und, cpol;
    bit          pushed;

    reset = 1'b0;
    wait_clk(4);
    check_reset_values("por");
    reset = 1'b1;
    wait_clk(4);

    // Mode 0: preloaded word goes out while 0xA5 comes in.
    select(0, 1'b0);
    push(16'h3C);
    check("m0_tx_ready_low", 32'(if0.tx_ready), 0);
    b_rxv = rxv_cnt[0]; b_ferr = ferr_cnt[0]; b_und = und_cnt[0];
    frame(0, 0, 8, 1'b1, 16'h00A5, 8, 1'b1, 1'b0, 16'h0, mi, fb);
    check("m0_miso_word", 32'(mi), 32'h3C);
    check("m0_first_bit", 32'(fb), 0);
    check("m0_rx_data", 32'(rx_of(0)), 32'hA5);
    check("m0_rx_valid_cnt", rxv_cnt[0] - b_rxv, 1);
    check("m0_frame_err_cnt", ferr_cnt[0] - b_ferr, 0);
    check("m0_underrun_cnt", und_snap[0] - b_und, 0);
    check("m0_tx_ready_high", 32'(if0.tx_ready), 1);

    // Modes 3 and 1 with the same bytes.
    for (int k = 1; k <= 2; k++) begin
      cpol = (k == 1) ? 1 : 0;
      select(k, 1'(cpol));
      push(16'h3C);
      check("m31_tx_ready_low", 32'(ready_of(k)), 0);
      b_rxv = rxv_cnt[k]; b_ferr = ferr_cnt[k];
      frame(cpol, 1, 8, 1'b1, 16'h00A5, 8, 1'b1, 1'b0, 16'h0, mi, fb);
      check("m31_miso_word", 32'(mi), 32'h3C);
      check("m31_bit7_early", 32'(fb), 0);
      check("m31_rx_data", 32'(rx_of(k)), 32'hA5);
      check("m31_rx_valid_cnt", rxv_cnt[k] - b_rxv, 1);
      check("m31_frame_err_cnt", ferr_cnt[k] - b_ferr, 0);
      check("m31_tx_ready_high", 32'(ready_of(k)), 1);
    end

    // Abort after 5 bits.
    select(0, 1'b0);
    b_rxv = rxv_cnt[0]; b_ferr = ferr_cnt[0];
    frame(0, 0, 8, 1'b1, 16'h00FF, 5, 1'b1, 1'b0, 16'h0, mi, fb);
    check("abort_frame_err_cnt", ferr_cnt[0] - b_ferr, 1);
    check("abort_rx_valid_cnt", rxv_cnt[0] - b_rxv, 0);
    check("abort_rx_data_kept", 32'(rx_of(0)), 32'hA5);
    check("abort_idle", 32'(if0.busy), 0);

    // Back-to-back frames with CS held low, holding register refilled mid-frame.
    push(16'hAA);
    b_rxv = rxv_cnt[0]; b_ferr = ferr_cnt[0];
    frame(0, 0, 8, 1'b1, 16'h0011, 8, 1'b0, 1'b1, 16'hBB, mi, fb);
    check("b2b_rx_first", 32'(rx_of(0)), 32'h11);
    frame(0, 0, 8, 1'b1, 16'h0022, 8, 1'b1, 1'b0, 16'h0, mi2, fb);
    check("b2b_miso_first", 32'(mi), 32'hAA);
    check("b2b_miso_second", 32'(mi2), 32'hBB);
    check("b2b_rx_second", 32'(rx_of(0)), 32'h22);
    check("b2b_rx_valid_cnt", rxv_cnt[0] - b_rxv, 2);
    check("b2b_frame_err_cnt", ferr_cnt[0] - b_ferr, 0);

    // Randomised frames: MISO is the pushed word or zeros, rx_data is what the master sent.
    for (int t = 0; t < 4; t++) begin
      w      = {8'h00, 8'($urandom)};
      e      = {8'h00, 8'($urandom)};
      pushed = 1'($urandom_range(0, 1));
      if (pushed) push(e);
      b_rxv = rxv_cnt[0];
      frame(0, 0, 8, 1'b1, w, 8, 1'b1, 1'b0, 16'h0, mi, fb);
      check("rnd_miso_word", 32'(mi), pushed ? 32'(e) : 32'h0);
      check("rnd_rx_data", 32'(rx_of(0)), 32'(w));
      check("rnd_rx_valid_cnt", rxv_cnt[0] - b_rxv, 1);
    end

    // Underrun, N=16, LSB first.
    select(3, 1'b0);
    b_rxv = rxv_cnt[3]; b_ferr = ferr_cnt[3]; b_und = und_cnt[3];
    frame(0, 0, 16, 1'b0, 16'h1234, 16, 1'b1, 1'b0, 16'h0, mi, fb);
    check("und_miso_zero", 32'(mi), 0);
    check("und_rx_data", 32'(rx_of(3)), 32'h1234);
    check("und_rx_valid_cnt", rxv_cnt[3] - b_rxv, 1);
    check("und_underrun_cnt", und_snap[3] - b_und, 1);
    check("und_frame_err_cnt", ferr_cnt[3] - b_ferr, 0);

    // Reset mid-frame, then a clean frame.
    select(0, 1'b0);
    b_ferr = ferr_cnt[0];
    frame(0, 0, 8, 1'b1, 16'h00C3, 3, 1'b0, 1'b0, 16'h0, mi, fb);
    push(16'h77);
    check("rst_tx_ready_full", 32'(if0.tx_ready), 0);
    reset = 1'b0;
    wait_clk(1);
    check_reset_values("midrst");
    m_cs  = 1'b1;
    m_sck = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);
    b_rxv = rxv_cnt[0];
    frame(0, 0, 8, 1'b1, 16'h005A, 8, 1'b1, 1'b0, 16'h0, mi, fb);
    check("post_rst_rx_data", 32'(rx_of(0)), 32'h5A);
    check("post_rst_miso_zero", 32'(mi), 0);
    check("post_rst_rx_valid_cnt", rxv_cnt[0] - b_rxv, 1);
    check("post_rst_frame_err_cnt", ferr_cnt[0] - b_ferr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
